// File: rtl/s_term_s1_loopback.sv
// Bottom-edge terminator: south-going wires are looped back north, one path per
// wire, with per-path invert and an optional capture stage (`S_TERM_PIPE_EN).
module s_term_s1_loopback #(
  parameter int NoConfigBits = 32
) (
  input  logic       UserCLK,
  input  logic       RESET,
  input  logic       from_SA_1s0,
  input  logic       from_SA_1s1,
  input  logic       from_SB_1s0,
  input  logic       from_SB_1s1,
  input  logic       from_SC_1s0,
  input  logic       from_SC_1s1,
  input  logic       from_SD_1s0,
  input  logic       from_SD_1s1,
  input  logic       from_SF_1s0,
  input  logic       from_SF_1s1,
  input  logic       from_SG_1s0,
  input  logic       from_SG_1s1,
  input  logic       from_SH_1s0,
  input  logic       from_SH_1s1,
  input  logic       from_SI_1s0,
  input  logic       from_SI_1s1,
  output logic       to_NA_1s0,
  output logic       to_NA_1s1,
  output logic       to_NB_1s0,
  output logic       to_NB_1s1,
  output logic       to_NC_1s0,
  output logic       to_NC_1s1,
  output logic       to_ND_1s0,
  output logic       to_ND_1s1,
  output logic       to_NF_1s0,
  output logic       to_NF_1s1,
  output logic       to_NG_1s0,
  output logic       to_NG_1s1,
  output logic       to_NH_1s0,
  output logic       to_NH_1s1,
  output logic       to_NI_1s0,
  output logic       to_NI_1s1,
  input  logic       cfg_data,
  input  logic       cfg_valid,
  output logic       cfg_ready,
  input  logic       cfg_abort,
  output logic       cfg_done,
  output logic [1:0] cfg_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } state_t;

  state_t                  state;
  logic [NoConfigBits-1:0] shadow;
  logic [NoConfigBits-1:0] active_cfg;
  logic [4:0]              beat_cnt;
  logic                    beat_ok;
  logic [15:0]             from_s;
  logic [15:0]             to_n;
  logic [15:0]             reg_sel;
  logic [15:0]             inv;

  // Path index k: letter-major, share-minor. Each bit only ever meets itself.
  assign from_s = {from_SI_1s1, from_SI_1s0, from_SH_1s1, from_SH_1s0,
                   from_SG_1s1, from_SG_1s0, from_SF_1s1, from_SF_1s0,
                   from_SD_1s1, from_SD_1s0, from_SC_1s1, from_SC_1s0,
                   from_SB_1s1, from_SB_1s0, from_SA_1s1, from_SA_1s0};

  assign to_NA_1s0 = to_n[0];
  assign to_NA_1s1 = to_n[1];
  assign to_NB_1s0 = to_n[2];
  assign to_NB_1s1 = to_n[3];
  assign to_NC_1s0 = to_n[4];
  assign to_NC_1s1 = to_n[5];
  assign to_ND_1s0 = to_n[6];
  assign to_ND_1s1 = to_n[7];
  assign to_NF_1s0 = to_n[8];
  assign to_NF_1s1 = to_n[9];
  assign to_NG_1s0 = to_n[10];
  assign to_NG_1s1 = to_n[11];
  assign to_NH_1s0 = to_n[12];
  assign to_NH_1s1 = to_n[13];
  assign to_NI_1s0 = to_n[14];
  assign to_NI_1s1 = to_n[15];

  assign reg_sel = active_cfg[15:0];
  assign inv     = active_cfg[31:16];

  // Handshake: a configuration bit transfers on a rising edge where
  // cfg_valid && cfg_ready && !cfg_abort; abort always drops the bit.
  assign cfg_ready = (state != COMMIT);
  assign beat_ok   = cfg_valid && cfg_ready && !cfg_abort;
  assign cfg_state = state;

  always_ff @(posedge UserCLK or posedge RESET) begin
    if (RESET) begin
      state      <= IDLE;
      shadow     <= '0;
      active_cfg <= '0;
      beat_cnt   <= 5'd0;
      cfg_done   <= 1'b0;
    end else begin
      cfg_done <= 1'b0;
      case (state)
        IDLE: begin
          if (beat_ok) begin
            shadow   <= {cfg_data, shadow[NoConfigBits-1:1]};
            beat_cnt <= beat_cnt + 5'd1;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          if (cfg_abort) begin
            state    <= IDLE;
            beat_cnt <= 5'd0;
            shadow   <= '0;
          end else if (beat_ok) begin
            shadow   <= {cfg_data, shadow[NoConfigBits-1:1]};
            beat_cnt <= beat_cnt + 5'd1;
            if (beat_cnt == 5'd31) state <= COMMIT;
          end
        end
        COMMIT: begin
          // Abort is not sampled here: a completed word always lands.
          active_cfg <= shadow;
          beat_cnt   <= 5'd0;
          cfg_done   <= 1'b1;
          state      <= IDLE;
        end
        default: begin
          state    <= IDLE;
          beat_cnt <= 5'd0;
        end
      endcase
    end
  end

`ifdef S_TERM_PIPE_EN
  logic [15:0] q;

  // Capture runs every cycle independent of reg_sel so a config change
  // only switches the mux, never disturbs the flop contents.
  always_ff @(posedge UserCLK or posedge RESET) begin
    if (RESET) q <= '0;
    else       q <= from_s;
  end

  assign to_n = ((reg_sel & q) | (~reg_sel & from_s)) ^ inv;
`else
  logic unused_reg_sel;

  assign unused_reg_sel = ^reg_sel;
  assign to_n           = from_s ^ inv;
`endif

endmodule

// File: tb/tb_s_term_s1_loopback.sv
// Directed bench for s_term_s1_loopback; expectations follow the build's
// S_TERM_PIPE_EN setting.
module tb_s_term_s1_loopback;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SHIFT  = 2'd1;
  localparam logic [1:0] ST_COMMIT = 2'd2;

  logic        UserCLK = 1'b0;
  logic        RESET   = 1'b1;
  logic [15:0] from_s  = 16'h0000;
  logic [15:0] to_n;
  logic        cfg_data  = 1'b0;
  logic        cfg_valid = 1'b0;
  logic        cfg_abort = 1'b0;
  logic        cfg_ready;
  logic        cfg_done;
  logic [1:0]  cfg_state;

  int errors = 0;
  int checks = 0;

  always #5 UserCLK = ~UserCLK;

  s_term_s1_loopback #(.NoConfigBits(32)) dut (
    .UserCLK(UserCLK), .RESET(RESET),
    .from_SA_1s0(from_s[0]),  .from_SA_1s1(from_s[1]),
    .from_SB_1s0(from_s[2]),  .from_SB_1s1(from_s[3]),
    .from_SC_1s0(from_s[4]),  .from_SC_1s1(from_s[5]),
    .from_SD_1s0(from_s[6]),  .from_SD_1s1(from_s[7]),
    .from_SF_1s0(from_s[8]),  .from_SF_1s1(from_s[9]),
    .from_SG_1s0(from_s[10]), .from_SG_1s1(from_s[11]),
    .from_SH_1s0(from_s[12]), .from_SH_1s1(from_s[13]),
    .from_SI_1s0(from_s[14]), .from_SI_1s1(from_s[15]),
    .to_NA_1s0(to_n[0]),  .to_NA_1s1(to_n[1]),
    .to_NB_1s0(to_n[2]),  .to_NB_1s1(to_n[3]),
    .to_NC_1s0(to_n[4]),  .to_NC_1s1(to_n[5]),
    .to_ND_1s0(to_n[6]),  .to_ND_1s1(to_n[7]),
    .to_NF_1s0(to_n[8]),  .to_NF_1s1(to_n[9]),
    .to_NG_1s0(to_n[10]), .to_NG_1s1(to_n[11]),
    .to_NH_1s0(to_n[12]), .to_NH_1s1(to_n[13]),
    .to_NI_1s0(to_n[14]), .to_NI_1s1(to_n[15]),
    .cfg_data(cfg_data), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_abort(cfg_abort), .cfg_done(cfg_done), .cfg_state(cfg_state)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge.
  task automatic cycle();
    @(posedge UserCLK);
    #1;
  endtask

  task automatic shift_bits(input logic [31:0] w, input int n);
    for (int i = 0; i < n; i++) begin
      cfg_valid = 1'b1;
      cfg_data  = w[i];
      cycle();
    end
    cfg_valid = 1'b0;
    cfg_data  = 1'b0;
  endtask

  // Full word plus commit timing: COMMIT right after beat 32, done one cycle later.
  task automatic load_word(input string tag, input logic [31:0] w);
    shift_bits(w, 32);
    check({tag, "_commit_state"}, {30'd0, cfg_state}, {30'd0, ST_COMMIT});
    check({tag, "_commit_ready"}, {31'd0, cfg_ready}, 32'd0);
    check({tag, "_commit_nodone"}, {31'd0, cfg_done}, 32'd0);
    cycle();
    check({tag, "_done"}, {31'd0, cfg_done}, 32'd1);
    check({tag, "_idle"}, {30'd0, cfg_state}, {30'd0, ST_IDLE});
    cycle();
    check({tag, "_done_clear"}, {31'd0, cfg_done}, 32'd0);
  endtask

  task automatic out_check(input string tag, input logic [15:0] f, input logic [15:0] exp);
    from_s = f;
    #1;
    check(tag, {16'd0, to_n}, {16'd0, exp});
  endtask

  initial begin
    // Reset held: passthrough must already be combinational.
    #2;
    out_check("rst_passthru", 16'hA5C3, 16'hA5C3);
    check("rst_ready", {31'd0, cfg_ready}, 32'd1);
    check("rst_done", {31'd0, cfg_done}, 32'd0);
    cycle();
    cycle();
    RESET = 1'b0;
    cycle();
    out_check("post_rst_passthru", 16'hA5C3, 16'hA5C3);
    check("post_rst_ready", {31'd0, cfg_ready}, 32'd1);
    check("post_rst_done", {31'd0, cfg_done}, 32'd0);
    check("post_rst_state", {30'd0, cfg_state}, {30'd0, ST_IDLE});

    // All paths registered (only effective with the capture stage built in).
    load_word("w_ffff", 32'h0000_FFFF);
    from_s = 16'h1111;
    cycle();
    from_s = 16'h2222;
    #1;
`ifdef S_TERM_PIPE_EN
    check("pipe_delay1", {16'd0, to_n}, 32'h0000_1111);
`else
    check("pipe_delay1", {16'd0, to_n}, 32'h0000_2222);
`endif
    cycle();
    from_s = 16'h3C3C;
    #1;
`ifdef S_TERM_PIPE_EN
    check("pipe_delay2", {16'd0, to_n}, 32'h0000_2222);
`else
    check("pipe_delay2", {16'd0, to_n}, 32'h0000_3C3C);
`endif

    // Invert all, combinational.
    load_word("w_inv", 32'hFFFF_0000);
    out_check("inv_1234", 16'h1234, 16'hEDCB);
    out_check("inv_00f0", 16'h00F0, 16'hFF0F);

    // 17 beats, then abort together with valid.
    shift_bits(32'h0000_00FF, 17);
    check("partial_state", {30'd0, cfg_state}, {30'd0, ST_SHIFT});
    cfg_valid = 1'b1;
    cfg_abort = 1'b1;
    cfg_data  = 1'b1;
    cycle();
    cfg_valid = 1'b0;
    cfg_abort = 1'b0;
    check("abort_state", {30'd0, cfg_state}, {30'd0, ST_IDLE});
    check("abort_nodone", {31'd0, cfg_done}, 32'd0);
    cycle();
    check("abort_nodone2", {31'd0, cfg_done}, 32'd0);
    out_check("abort_cfg_kept", 16'h1234, 16'hEDCB);
    load_word("w_after_abort", 32'h5A5A_0000);
    out_check("after_abort_out", 16'h0F0F, 16'h5555);

    // Abort in IDLE is ignored and does not disturb a later word.
    cfg_abort = 1'b1;
    cycle();
    cfg_abort = 1'b0;
    check("idle_abort_state", {30'd0, cfg_state}, {30'd0, ST_IDLE});

    // cfg_valid held 40 cycles: word A in cycles 0..31, COMMIT at 32,
    // word B starts at cycle 33.
    begin
      logic [31:0] wa;
      logic [31:0] wb;
      wa = 32'h00FF_0000;
      wb = 32'hC3C3_0000;
      from_s = 16'h0F0F;
      for (int i = 0; i < 40; i++) begin
        cfg_valid = 1'b1;
        if (i < 32)       cfg_data = wa[i];
        else if (i == 32) cfg_data = 1'b1;
        else              cfg_data = wb[i-33];
        #1;
        if (i == 31 || i == 32 || i == 33 || i == 39) begin
          check($sformatf("hold_ready_c%0d", i), {31'd0, cfg_ready}, {31'd0, (i != 32)});
          check($sformatf("hold_done_c%0d", i), {31'd0, cfg_done}, {31'd0, (i == 33)});
        end
        if (i == 33) check("hold_wa_out", {16'd0, to_n}, 32'h0000_0FF0);
        @(posedge UserCLK);
        #0;
      end
      #1;
      check("hold_state_mid_b", {30'd0, cfg_state}, {30'd0, ST_SHIFT});
      for (int i = 7; i < 32; i++) begin
        cfg_valid = 1'b1;
        cfg_data  = wb[i];
        cycle();
      end
      cfg_valid = 1'b0;
      check("hold_b_commit", {30'd0, cfg_state}, {30'd0, ST_COMMIT});
      cycle();
      check("hold_b_done", {31'd0, cfg_done}, 32'd1);
      out_check("hold_b_out", 16'h0F0F, 16'hCCCC);
    end

    // Reset at beat 20.
    cycle();
    shift_bits(32'hFFFF_FFFF, 20);
    from_s = 16'h6A6A;
    #2;
    RESET = 1'b1;
    #1;
    check("midrst_passthru", {16'd0, to_n}, 32'h0000_6A6A);
    check("midrst_state", {30'd0, cfg_state}, {30'd0, ST_IDLE});
    check("midrst_ready", {31'd0, cfg_ready}, 32'd1);
    check("midrst_done", {31'd0, cfg_done}, 32'd0);
    cycle();
    RESET = 1'b0;
    cycle();
    cycle();
    check("postrst_nodone", {31'd0, cfg_done}, 32'd0);
    // Counter must be back at 0: commit lands after exactly 32 more beats.
    load_word("w_postrst", 32'h0001_0000);
    out_check("postrst_out", 16'h0000, 16'h0001);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
